// File: rtl/hdlc_rx_deframer_if.sv
// Line-side and deframer-output signal bundle of the HDLC receive front end.
// master: drives the raw line bit and its enable; slave: the deframer itself.
interface hdlc_rx_deframer_if;
    logic       Rx;
    logic       RxEN;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_ValidFrame;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_EoF;
    logic       Rx_FrameError;
    logic       Rx_ZeroDetect;

    modport master (
        output Rx, RxEN,
        input  Rx_Data, Rx_NewByte, Rx_ValidFrame, Rx_FlagDetect,
        input  Rx_AbortDetect, Rx_EoF, Rx_FrameError, Rx_ZeroDetect
    );

    modport slave (
        input  Rx, RxEN,
        output Rx_Data, Rx_NewByte, Rx_ValidFrame, Rx_FlagDetect,
        output Rx_AbortDetect, Rx_EoF, Rx_FrameError, Rx_ZeroDetect
    );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunting, abort detection, zero de-stuffing and
// byte assembly. Data bits are taken from the far end of an 8-bit raw window,
// so a closing flag is recognised on the same edge its preceding data bit
// leaves the window, and flag bits themselves never reach the assembler.
module hdlc_rx_deframer #(
    parameter int unsigned MIN_BYTES = 2
) (
    input logic               Clk,
    input logic               Rst,
    hdlc_rx_deframer_if.slave bus
);

    typedef enum logic [1:0] {StHunt, StFlagSeen, StInFrame} state_e;

    state_e     state_q, state_d, st_taken;
    logic [7:0] win_q, win_d;
    logic [3:0] fill_q, fill_d;
    logic [2:0] ones_q, ones_d;
    logic [7:0] asm_q, asm_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] data_q, data_d;
    logic       new_byte_q, new_byte_d;
    logic       valid_q, valid_d;
    logic       flag_q, flag_d;
    logic       abort_q, abort_d;
    logic       eof_q, eof_d;
    logic       err_q, err_d;
    logic       zero_q, zero_d;

    logic [7:0] win_shift;
    logic       is_flag, is_abort, take, drop, push, byte_done;

    // Next-state: window shift, de-stuffing, assembly and frame state machine
    always_comb begin
        win_shift = {bus.Rx, win_q[7:1]};
        is_flag   = bus.RxEN && (win_shift == 8'h7E);
        is_abort  = bus.RxEN && (win_shift[7:1] == 7'h7F);
        take      = bus.RxEN && (fill_q == 4'd8) && (state_q != StHunt);
        drop      = take && (ones_q == 3'd5) && !win_q[0];
        push      = take && !drop;
        byte_done = push && (bit_cnt_q == 3'd7);

        win_d      = win_q;
        fill_d     = fill_q;
        ones_d     = ones_q;
        asm_d      = asm_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        new_byte_d = 1'b0;
        flag_d     = 1'b0;
        abort_d    = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;
        zero_d     = drop;

        if (bus.RxEN) begin
            win_d  = win_shift;
            fill_d = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
        end

        if (take) begin
            if (drop || !win_q[0]) begin
                ones_d = 3'd0;
            end else begin
                ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
            end
        end

        if (push) begin
            asm_d     = {win_q[0], asm_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (byte_done) begin
            data_d     = {win_q[0], asm_q[7:1]};
            new_byte_d = 1'b1;
            if (byte_cnt_q != 8'hFF) begin
                byte_cnt_d = byte_cnt_q + 8'd1;
            end
        end

        // The first kept data bit after a flag opens the frame on this very edge
        st_taken = state_q;
        if (state_q == StFlagSeen && push) begin
            st_taken = StInFrame;
        end
        state_d = st_taken;

        if (is_abort) begin
            // A partially received byte is discarded along with the frame
            abort_d    = (st_taken == StInFrame);
            state_d    = StHunt;
            data_d     = data_q;
            new_byte_d = 1'b0;
            asm_d      = 8'h00;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
            ones_d     = 3'd0;
        end else if (is_flag) begin
            flag_d = 1'b1;
            fill_d = 4'd0;
            if (st_taken == StInFrame) begin
                // Judged on counters that already include this edge's data bit
                eof_d = 1'b1;
                err_d = (bit_cnt_d != 3'd0) || (32'(byte_cnt_d) < MIN_BYTES);
            end
            state_d    = StFlagSeen;
            asm_d      = 8'h00;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
            ones_d     = 3'd0;
        end

        valid_d = (state_d == StInFrame);
    end

    // State and registered outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= StHunt;
            win_q      <= 8'h00;
            fill_q     <= 4'd0;
            ones_q     <= 3'd0;
            asm_q      <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            data_q     <= 8'h00;
            new_byte_q <= 1'b0;
            valid_q    <= 1'b0;
            flag_q     <= 1'b0;
            abort_q    <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            fill_q     <= fill_d;
            ones_q     <= ones_d;
            asm_q      <= asm_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            new_byte_q <= new_byte_d;
            valid_q    <= valid_d;
            flag_q     <= flag_d;
            abort_q    <= abort_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.Rx_Data        = data_q;
    assign bus.Rx_NewByte     = new_byte_q;
    assign bus.Rx_ValidFrame  = valid_q;
    assign bus.Rx_FlagDetect  = flag_q;
    assign bus.Rx_AbortDetect = abort_q;
    assign bus.Rx_EoF         = eof_q;
    assign bus.Rx_FrameError  = err_q;
    assign bus.Rx_ZeroDetect  = zero_q;

endmodule
